// File: rtl/adders_pkg.sv
// adders_pkg: shared constants for the adders library (FSM state encoding,
// default operand width).
package adders_pkg;

  localparam int ADD_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub1bit.sv
// sub1bit: combinational full subtractor, d = a - b - br_in with borrow out.
module sub1bit (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/sub_serial.sv
// sub_serial: bit-serial a - b - b_in, LSB first, with start/busy/done handshake.
// Define SUB_SERIAL_OVF_EN to add the signed-overflow output ovf.
module sub_serial
  import adders_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-2:0] res_r;
  logic [WIDTH-1:0] res_next_s;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic             d_s;
  logic             br_next_s;
`ifdef SUB_SERIAL_OVF_EN
  logic             a_msb_r;
  logic             b_msb_r;
`endif

  sub1bit u_bit (
    .a      (a_sh_r[0]),
    .b      (b_sh_r[0]),
    .br_in  (br_r),
    .d      (d_s),
    .br_out (br_next_s)
  );

  // The result bit of this cycle enters from the MSB side; the LSB falls off.
  assign res_next_s = {d_s, res_r};

  // Next-state logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) state_next_s = ST_DONE;
        else                   state_next_s = ST_RUN;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Handshake outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next_s != ST_IDLE);
      done <= (state_next_s == ST_DONE);
    end
  end

  // Operand capture, serial datapath and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      res_r   <= '0;
      br_r    <= 1'b0;
      cnt_r   <= '0;
      diff    <= '0;
      b_out   <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            br_r    <= b_in;
            res_r   <= '0;
            cnt_r   <= '0;
`ifdef SUB_SERIAL_OVF_EN
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
          br_r   <= br_next_s;
          res_r  <= res_next_s[WIDTH-1:1];
          // Counter stops at the last bit so it never wraps inside an operation.
          if (cnt_r == CNT_LAST) begin
            diff  <= res_next_s;
            b_out <= br_next_s;
`ifdef SUB_SERIAL_OVF_EN
            ovf   <= (a_msb_r ^ b_msb_r) & (d_s ^ a_msb_r);
`endif
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          br_r <= br_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: randomized and directed self-checking bench for sub_serial
// against a plain-arithmetic subtraction model.
module tb_sub_serial;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         b_in  = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
`ifdef SUB_SERIAL_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  sub_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef SUB_SERIAL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: {b_out, diff} from integer subtraction.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic bin);
    int r;
    logic [W-1:0] d;
    r = int'(av) - int'(bv) - int'(bin);
    d = W'((r < 0) ? r + (1 << W) : r);
    return {(r < 0), d};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic [W-1:0] d);
    return (av[W-1] ^ bv[W-1]) & (d[W-1] ^ av[W-1]);
  endfunction

  function automatic logic cur_ovf();
`ifdef SUB_SERIAL_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // One non-overlapping operation; records result, latency, busy samples.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin,
                        output logic [W-1:0] d_o, output logic bo_o, output logic ov_o,
                        output int lat, output int busy_cnt, output logic tail);
    @(negedge clk);
    a = av; b = bv; b_in = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    lat = -1; d_o = '0; bo_o = 1'b0; ov_o = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k; d_o = diff; bo_o = b_out; ov_o = cur_ovf();
        break;
      end
    end
    @(posedge clk); #1;
    tail = done | busy;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({busy, done, diff, b_out, cur_ovf()} !== '0)
      $display("FAIL reset_state: got busy=%b done=%b diff=%h b_out=%b ovf=%b, want all 0",
               busy, done, diff, b_out, cur_ovf());
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [3] = '{4'd9, 4'd3, 4'd0};
    logic [W-1:0] tb [3] = '{4'd3, 4'd9, 4'd0};
    logic         tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] te [3] = '{4'd6, 4'hA, 4'hF};
    logic         tbo[3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] d; logic bo, ov, tail; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], tc[i], d, bo, ov, lat, bc, tail);
      n_checks++;
      if ({bo, d} !== {tbo[i], te[i]})
        $display("FAIL directed_result[%0d]: got b_out=%b diff=%h, want b_out=%b diff=%h",
                 i, bo, d, tbo[i], te[i]);
      else n_pass++;
      n_checks++;
      if (lat !== W) $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, W);
      else n_pass++;
      n_checks++;
      if (bc !== W + 1) $display("FAIL directed_busy[%0d]: got %0d cycles, want %0d", i, bc, W + 1);
      else n_pass++;
      n_checks++;
      if (tail !== 1'b0) $display("FAIL directed_tail[%0d]: busy|done=%b after done, want 0", i, tail);
      else n_pass++;
    end
  endtask

  task automatic test_start_while_busy();
    int lat = -1;
    int extra = 0;
    @(negedge clk);
    a = 4'd9; b = 4'd3; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; a = 4'd15; b = 4'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 4; k <= 20; k++) begin
      if (done) begin lat = k - 1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if ({b_out, diff} !== {1'b0, 4'd6} || lat < 0)
      $display("FAIL start_while_busy: got b_out=%b diff=%h seen=%0d, want b_out=0 diff=6",
               b_out, diff, lat);
    else n_pass++;
    repeat (10) begin @(posedge clk); #1; if (busy || done) extra++; end
    n_checks++;
    if (extra !== 0) $display("FAIL start_while_busy_relaunch: busy cycles=%0d, want 0", extra);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    logic [W-1:0] d; logic bo, ov, tail; int lat, bc;
    @(negedge clk);
    a = 4'd12; b = 4'd5; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    n_checks++;
    if ({busy, done, diff, b_out, cur_ovf()} !== '0)
      $display("FAIL reset_mid_run: got busy=%b done=%b diff=%h b_out=%b, want all 0",
               busy, done, diff, b_out);
    else n_pass++;
    repeat (3) begin @(posedge clk); #1; if (done) seen++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (done || busy) seen++; end
    n_checks++;
    if (seen !== 0) $display("FAIL reset_mid_run_no_done: activity=%0d, want 0", seen);
    else n_pass++;
    run_op(4'd5, 4'd5, 1'b0, d, bo, ov, lat, bc, tail);
    n_checks++;
    if ({bo, d, lat} !== {1'b0, 4'd0, W})
      $display("FAIL reset_recover: got b_out=%b diff=%h lat=%0d, want 0 0 %0d", bo, d, lat, W);
    else n_pass++;
  endtask

`ifdef SUB_SERIAL_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] d; logic bo, ov, tail; int lat, bc;
    run_op(4'h8, 4'd1, 1'b0, d, bo, ov, lat, bc, tail);
    n_checks++;
    if ({d, ov} !== {4'd7, 1'b1}) $display("FAIL ovf_8m1: got diff=%h ovf=%b, want 7 1", d, ov);
    else n_pass++;
    run_op(4'h7, 4'd1, 1'b0, d, bo, ov, lat, bc, tail);
    n_checks++;
    if ({d, ov} !== {4'd6, 1'b0}) $display("FAIL ovf_7m1: got diff=%h ovf=%b, want 6 0", d, ov);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] av, bv, d; logic bin, bo, ov, tail; int lat, bc;
    logic [W:0] exp;
    for (int i = 0; i < 30; i++) begin
      av = W'($urandom); bv = W'($urandom); bin = 1'($urandom);
      exp = ref_sub(av, bv, bin);
      run_op(av, bv, bin, d, bo, ov, lat, bc, tail);
      n_checks++;
      if ({bo, d} !== exp || lat !== W || ov !== (cur_ovf() & ref_ovf(av, bv, exp[W-1:0])))
        $display("FAIL random[%0d] %h-%h-%b: got b_out=%b diff=%h ovf=%b lat=%0d, want %b %h lat=%0d",
                 i, av, bv, bin, bo, d, ov, lat, exp[W], exp[W-1:0], W);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av, bv; logic bin; logic [W:0] exp;
    logic [8:0] idx;
    start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      idx = 9'(i);
      av = idx[8:5]; bv = idx[4:1]; bin = idx[0];
      exp = ref_sub(av, bv, bin);
      @(negedge clk);
      a = av; b = bv; b_in = bin;
      @(posedge clk);
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      repeat (W) @(posedge clk);
      #1;
      n_checks++;
      if ({done, b_out, diff} !== {1'b1, exp} ||
          cur_ovf() !== (cur_ovf() === 1'b0 ? 1'b0 : ref_ovf(av, bv, exp[W-1:0])))
        $display("FAIL back_to_back[%0d] %h-%h-%b: got done=%b b_out=%b diff=%h, want 1 %b %h",
                 i, av, bv, bin, done, b_out, diff, exp[W], exp[W-1:0]);
      else n_pass++;
`ifdef SUB_SERIAL_OVF_EN
      n_checks++;
      if (ovf !== ref_ovf(av, bv, exp[W-1:0]))
        $display("FAIL back_to_back_ovf[%0d]: got %b, want %b", i, ovf, ref_ovf(av, bv, exp[W-1:0]));
      else n_pass++;
`endif
      @(posedge clk);
    end
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid_run();
`ifdef SUB_SERIAL_OVF_EN
    test_ovf();
`endif
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
